serial_comparator: RTL and testbench



---
 rtl/serial_comparator_pkg.sv | 29 ++
 rtl/serial_comparator.sv | 44 ++++
 tb/tb_serial_comparator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: state encoding,
// flag bundle and the state-to-flag decode.
package serial_comparator_pkg;

   typedef enum logic [1:0] {
      EQ = 2'b00,
      GT = 2'b01,
      LT = 2'b10
   } cmp_state_t;

   typedef struct packed {
      logic g;
      logic e;
      logic l;
   } cmp_flags_t;

   // The unused encoding 2'b11 falls into the default arm and reads as equal
   function automatic cmp_flags_t decodeFlags(input cmp_state_t s);
      cmp_flags_t f;
      f = '{g: 1'b0, e: 1'b1, l: 1'b0};
      case (s)
         GT:      f = '{g: 1'b1, e: 1'b0, l: 1'b0};
         LT:      f = '{g: 1'b0, e: 1'b0, l: 1'b1};
         default: f = '{g: 1'b0, e: 1'b1, l: 1'b0};
      endcase
      return f;
   endfunction

endpackage

// File: rtl/serial_comparator.sv
// Bit-serial unsigned comparator, MSB first. The first differing bit pair
// latches GT or LT until the next reset; flags decode only from the state register.
module serial_comparator
   import serial_comparator_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic g,
   output logic e,
   output logic l
);

   cmp_state_t state;
   cmp_flags_t flags;

   // GT and LT are absorbing, so only the EQ state looks at the data bits
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= EQ;
      end else begin
         case (state)
            EQ: begin
               if (a && !b)
                  state <= GT;
               else if (!a && b)
                  state <= LT;
               else
                  state <= EQ;
            end
            GT:      state <= GT;
            LT:      state <= LT;
            default: state <= EQ;
         endcase
      end
   end

   assign flags = decodeFlags(state);
   assign g     = flags.g;
   assign e     = flags.e;
   assign l     = flags.l;

endmodule

// File: tb/tb_serial_comparator.sv
// Testbench for serial_comparator: directed vector table, exhaustive 4-bit sweep
// and random variable-length operands checked against integer comparison.
module tb_serial_comparator;

   logic clock;
   logic reset;
   logic a;
   logic b;
   logic g;
   logic e;
   logic l;

   int checks;
   int passes;

   typedef struct {
      logic       r;
      logic       a;
      logic       b;
      logic [2:0] exp;
   } vec_t;

   localparam logic [2:0] FGT = 3'b100;
   localparam logic [2:0] FEQ = 3'b010;
   localparam logic [2:0] FLT = 3'b001;

   vec_t vecs[$];

   serial_comparator dut (
      .clock (clock),
      .reset (reset),
      .a     (a),
      .b     (b),
      .g     (g),
      .e     (e),
      .l     (l)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic r, input logic va, input logic vb, input logic [2:0] ex);
      vec_t v;
      v.r   = r;
      v.a   = va;
      v.b   = vb;
      v.exp = ex;
      return v;
   endfunction

   function automatic logic [2:0] refFlags(input longint unsigned x, input longint unsigned y);
      if (x > y) return FGT;
      if (x < y) return FLT;
      return FEQ;
   endfunction

   // Inputs change 1 time unit after an edge; outputs are sampled at the same point
   task automatic applyStimulus(input logic r, input logic va, input logic vb);
      reset = r;
      a     = va;
      b     = vb;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] exp);
      checks++;
      if ({g, e, l} === exp)
         passes++;
      else
         $display("[TB] FAIL %s: got gel=%b expected gel=%b", name, {g, e, l}, exp);
   endtask

   task automatic checkOneHot(input string name);
      checks++;
      if ($countones({g, e, l}) == 1 && !$isunknown({g, e, l}))
         passes++;
      else
         $display("[TB] FAIL %s: got gel=%b expected exactly one flag high", name, {g, e, l});
   endtask

   initial begin
      longint unsigned va;
      longint unsigned vb;
      logic            ba;
      logic            bb;
      int              len;
      logic [3:0]      xa;
      logic [3:0]      xb;

      checks = 0;
      passes = 0;
      reset  = 1'b1;
      a      = 1'b0;
      b      = 1'b0;

      // Directed table: 0101 vs 0011
      vecs.push_back(mk(1, 0, 0, FEQ));
      vecs.push_back(mk(0, 0, 0, FEQ));
      vecs.push_back(mk(0, 1, 0, FGT));
      vecs.push_back(mk(0, 0, 1, FGT));
      vecs.push_back(mk(0, 1, 1, FGT));
      // 0011 vs 0101, LT visible after edge 2
      vecs.push_back(mk(1, 1, 1, FEQ));
      vecs.push_back(mk(0, 0, 0, FEQ));
      vecs.push_back(mk(0, 0, 1, FLT));
      vecs.push_back(mk(0, 1, 0, FLT));
      vecs.push_back(mk(0, 1, 1, FLT));
      // 1001 vs 1001
      vecs.push_back(mk(1, 0, 1, FEQ));
      vecs.push_back(mk(0, 1, 1, FEQ));
      vecs.push_back(mk(0, 0, 0, FEQ));
      vecs.push_back(mk(0, 0, 0, FEQ));
      vecs.push_back(mk(0, 1, 1, FEQ));
      // 1000 vs 0111: MSB decides
      vecs.push_back(mk(1, 0, 0, FEQ));
      vecs.push_back(mk(0, 1, 0, FGT));
      vecs.push_back(mk(0, 0, 1, FGT));
      vecs.push_back(mk(0, 0, 1, FGT));
      vecs.push_back(mk(0, 0, 1, FGT));
      // Mid-operand reset, reset wins over differing data, then 0010 vs 0100
      vecs.push_back(mk(1, 0, 0, FEQ));
      vecs.push_back(mk(0, 1, 0, FGT));
      vecs.push_back(mk(1, 1, 0, FEQ));
      vecs.push_back(mk(0, 0, 0, FEQ));
      vecs.push_back(mk(0, 0, 1, FLT));
      vecs.push_back(mk(0, 1, 0, FLT));
      vecs.push_back(mk(0, 0, 0, FLT));
      // Reset out of LT with data that would favour LT
      vecs.push_back(mk(1, 0, 1, FEQ));
      // Extra edges after an equal result extend the comparison
      vecs.push_back(mk(0, 1, 1, FEQ));
      vecs.push_back(mk(0, 0, 1, FLT));
      vecs.push_back(mk(0, 1, 0, FLT));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].r, vecs[i].a, vecs[i].b);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Exhaustive 4-bit sweep with one reset cycle between pairs
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            xa = 4'(i);
            xb = 4'(j);
            applyStimulus(1'b1, 1'b0, 1'b0);
            for (int k = 3; k >= 0; k--)
               applyStimulus(1'b0, xa[k], xb[k]);
            checkOutput($sformatf("sweep a=%0d b=%0d", i, j), refFlags(longint'(i), longint'(j)));
            checkOneHot($sformatf("onehot a=%0d b=%0d", i, j));
         end
      end

      // Random operands of varying length, with occasional mid-operand reset
      for (int n = 0; n < 40; n++) begin
         len = $urandom_range(1, 24);
         applyStimulus(1'b1, 1'($urandom), 1'($urandom));
         va = 0;
         vb = 0;
         checkOutput($sformatf("rnd%0d reset", n), FEQ);
         for (int k = 0; k < len; k++) begin
            ba = 1'($urandom);
            bb = ($urandom_range(0, 3) == 0) ? 1'($urandom) : ba;
            if ($urandom_range(0, 31) == 0) begin
               applyStimulus(1'b1, ba, bb);
               va = 0;
               vb = 0;
            end else begin
               applyStimulus(1'b0, ba, bb);
               va = (va << 1) | longint'(ba);
               vb = (vb << 1) | longint'(bb);
            end
            checkOutput($sformatf("rnd%0d bit%0d", n, k), refFlags(va, vb));
         end
      end

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
